// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute ALU: opcode encodings and controller states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1011,
    OP_NOR   = 4'b1100,
    OP_MULTU = 4'b1110
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } fsm_state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between decode, the ALU and writeback.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             illegal_op;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, hi, zero, overflow, carry_out, illegal_op
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, hi, zero, overflow, carry_out, illegal_op
  );
endinterface

// File: rtl/alu_word_comb.sv
// Single-cycle word datapath: logic ops, add/sub with flags, signed/unsigned compare.
module alu_word_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             illegal_op_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic           add_ov;
  logic           sub_ov;
  logic           slt_bit;
  logic           sltu_bit;

  assign add_full = {1'b0, a_i} + {1'b0, b_i};
  assign sub_full = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  assign add_ov   = (a_i[MSB] == b_i[MSB])  & (add_full[MSB] != a_i[MSB]);
  assign sub_ov   = (a_i[MSB] == ~b_i[MSB]) & (sub_full[MSB] != a_i[MSB]);
  // Sign of the difference is wrong exactly when it overflowed.
  assign slt_bit  = sub_full[MSB] ^ sub_ov;
  assign sltu_bit = ~sub_full[WIDTH];

  always_comb begin
    result_o     = '0;
    carry_out_o  = 1'b0;
    overflow_o   = 1'b0;
    illegal_op_o = 1'b0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_ADD: begin
        result_o    = add_full[MSB:0];
        carry_out_o = add_full[WIDTH];
        overflow_o  = add_ov;
      end
      OP_SUB: begin
        result_o    = sub_full[MSB:0];
        carry_out_o = sub_full[WIDTH];
        overflow_o  = sub_ov;
      end
      OP_SLT:   result_o = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU:  result_o = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_MULTU: result_o = '0;
      default:  illegal_op_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative shift-add MULTU,
// with valid/ready handshakes on both the operand and result sides.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  alu_multicycle_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  fsm_state_t       state_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_q;
  logic             illegal_q;
  logic             out_valid_q;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               in_ready;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_d;

  logic [WIDTH-1:0] comb_result;
  logic             comb_carry;
  logic             comb_overflow;
  logic             comb_illegal;

  alu_word_comb #(.WIDTH(WIDTH)) u_word (
    .op_i         (bus.op),
    .a_i          (bus.a),
    .b_i          (bus.b),
    .result_o     (comb_result),
    .carry_out_o  (comb_carry),
    .overflow_o   (comb_overflow),
    .illegal_op_o (comb_illegal)
  );

  assign in_ready = (state_q == S_IDLE) & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Add into the upper half keeping the carry, then shift the whole {carry, acc} right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_d   = {mul_sum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MULTU) begin
              mcand_q     <= bus.a;
              mplier_q    <= bus.b;
              acc_q       <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              state_q     <= S_MUL;
            end else begin
              result_q    <= comb_result;
              hi_q        <= '0;
              zero_q      <= (comb_result == '0);
              overflow_q  <= comb_overflow;
              carry_q     <= comb_carry;
              illegal_q   <= comb_illegal;
              out_valid_q <= 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            result_q    <= acc_q[WIDTH-1:0];
            hi_q        <= acc_q[2*WIDTH-1:WIDTH];
            zero_q      <= (acc_q[WIDTH-1:0] == '0);
            overflow_q  <= 1'b0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.hi         = hi_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = overflow_q;
  assign bus.carry_out  = carry_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer an op at a falling edge once in_ready is up; returns one falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("issue_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0BAD_F00D;
  endtask

  initial begin
    int lat;
    int busy;
    int stable;

    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'b0000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    64'(bus.result),    64'd0);
    check("rst_hi",        64'(bus.hi),        64'd0);
    check("rst_flags", 64'({bus.zero, bus.overflow, bus.carry_out, bus.illegal_op}), 64'd0);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_valid",  64'(bus.out_valid), 64'd1);
    check("add_result", 64'(bus.result),    64'h8000_0000);
    check("add_ovf",    64'(bus.overflow),  64'd1);
    check("add_carry",  64'(bus.carry_out), 64'd0);
    check("add_zero",   64'(bus.zero),      64'd0);

    issue(OP_SUB, 32'd5, 32'd5);
    check("sub_eq_result", 64'(bus.result),    64'd0);
    check("sub_eq_zero",   64'(bus.zero),      64'd1);
    check("sub_eq_carry",  64'(bus.carry_out), 64'd1);
    check("sub_eq_ovf",    64'(bus.overflow),  64'd0);

    issue(OP_SUB, 32'd0, 32'd1);
    check("sub_brw_result", 64'(bus.result),    64'hFFFF_FFFF);
    check("sub_brw_carry",  64'(bus.carry_out), 64'd0);

    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg", 64'(bus.result), 64'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    check("sltu_big", 64'(bus.result), 64'd0);
    issue(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
    check("slt_ovf", 64'(bus.result), 64'd1);
    check("slt_flags", 64'({bus.overflow, bus.carry_out}), 64'd0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat  = 0;
    busy = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.in_ready) busy++;
      lat++;
      @(negedge clk);
    end
    check("mul_latency", 64'(lat),  64'd33);
    check("mul_busy",    64'(busy), 64'd33);
    check("mul_hold_rdy", 64'(bus.in_ready), 64'd0);
    check("mul_hi",      64'(bus.hi),     64'hFFFF_FFFE);
    check("mul_lo",      64'(bus.result), 64'h0000_0001);
    check("mul_zero",    64'(bus.zero),   64'd0);

    issue(OP_MULTU, 32'h0000_1234, 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check("mul0_valid", 64'(bus.out_valid), 64'd1);
    check("mul0_hi",    64'(bus.hi),        64'd0);
    check("mul0_lo",    64'(bus.result),    64'd0);
    check("mul0_zero",  64'(bus.zero),      64'd1);

    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    bus.out_ready = 1'b0;
    check("and_result", 64'(bus.result), 64'h0000_F000);
    check("and_hi",     64'(bus.hi),     64'd0);
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.result == 32'h0000_F000 && !bus.in_ready) stable++;
    end
    check("bp_stable", 64'(stable), 64'd5);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_OR;
    bus.a         = 32'h0000_0F0F;
    bus.b         = 32'h0000_00F0;
    #1;
    check("bp_drain_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("or_valid",  64'(bus.out_valid), 64'd1);
    check("or_result", 64'(bus.result),    64'h0000_0FFF);
    @(negedge clk);
    check("drain_drop", 64'(bus.out_valid), 64'd0);

    issue(OP_MULTU, 32'h0001_0001, 32'h0000_0003);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_ready", 64'(bus.in_ready),  64'd1);
    check("mrst_hi",    64'(bus.hi),        64'd0);

    issue(OP_NOR, 32'd0, 32'd0);
    check("nor_result", 64'(bus.result), 64'hFFFF_FFFF);
    check("nor_illegal", 64'(bus.illegal_op), 64'd0);

    issue(4'b0101, 32'h0000_1234, 32'h0000_5678);
    check("ill_flag",   64'(bus.illegal_op), 64'd1);
    check("ill_result", 64'(bus.result),     64'd0);
    check("ill_zero",   64'(bus.zero),       64'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
WIDTH-bit MIPS-style execute-stage ALU. It generalises the 1-bit and/or/add/less slice to a full word and adds SUB, NOR, SLTU, overflow/zero flags and an iterative unsigned multiply (MULTU).
- Registered output with a valid/ready handshake on both sides.
- Sits between the decode/register-read stage and the writeback/HI-LO logic of each core.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept an operation this cycle
op  in  4  operation code (alu_op_t)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  result (LO word for MULTU)
hi  out  WIDTH  HI word for MULTU, 0 for all other ops
zero  out  1  result == 0
overflow  out  1  signed overflow, ADD/SUB only, else 0
carry_out  out  1  carry out of MSB for ADD/SUB (SUB: 1 = no borrow), else 0
illegal_op  out  1  op not in encoding list; result forced 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: FSM=IDLE, out_valid=0, result/hi=0, all flags 0, counter=0. in_ready=1 from the first cycle after reset deasserts.
- Opcodes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SLTU=1011, NOR=1100, MULTU=1110. Any other code gives illegal_op=1.
- Accept: an op is accepted when in_valid & in_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Accept on the same cycle a result drains is allowed.
- FSM states: IDLE, MUL, HOLD.
  - IDLE, non-MULTU accept: combinational datapath result registered; out_valid=1 next cycle (latency 1). Stay IDLE.
  - IDLE, MULTU accept: latch a into multiplicand, b into multiplier shift register, clear the 2*WIDTH accumulator, counter=0 -> MUL.
  - MUL: each cycle, if multiplier LSB is 1, add the multiplicand into the upper accumulator half (WIDTH+1-bit add). Shift {carry, acc} right by 1; shift multiplier right; counter++.
  - MUL exit: after WIDTH iterations, load hi=acc[2W-1:W] and result=acc[W-1:0], set out_valid -> HOLD. Accept-to-out_valid latency is WIDTH+1 cycles.
  - HOLD: wait for out_ready -> IDLE. in_ready=0 throughout MUL and HOLD.
- Backpressure: while out_valid & !out_ready, result, hi and all flags hold stable. No new op is accepted.
- Arithmetic:
  - SUB = a + ~b + 1.
  - overflow = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]), where b' is the inverted b for SUB.
  - SLT = sub_sign XOR sub_overflow, zero-extended.
  - SLTU = !sub_carry, zero-extended.
  - NOR = ~(a|b).
- zero is computed from the registered result, including for MULTU (LO only).
- out_valid is dropped on out_ready unless a new op is accepted in the same cycle.
- Reset mid-MULTU: iteration abandoned, partial product discarded, out_valid=0, in_ready=1 the next cycle.
- Inputs a, b and op are sampled only on accept; changes at other times have no effect.

Decomposition:
- Package alu_pkg: alu_op_t enum (4-bit opcodes above) and fsm_state_t (IDLE/MUL/HOLD).
- Sub-module alu_word_comb: purely combinational WIDTH-bit datapath. Produces result, carry_out, overflow, illegal_op for all single-cycle ops.
- The top level owns the FSM, the handshake, the output registers and the shift-add multiplier.

Test Plan:
1. ADD a=0x7FFFFFFF b=0x00000001 -> next cycle out_valid=1, result=0x80000000, overflow=1, carry_out=0, zero=0.
2. SUB a=5 b=5 -> result=0, zero=1, carry_out=1, overflow=0. SUB a=0 b=1 -> result=0xFFFFFFFF, carry_out=0.
3. SLT a=0xFFFFFFFF b=1 -> result=1. SLTU same operands -> result=0. SLT a=0x80000000 b=0x7FFFFFFF -> result=1 (overflow case).
4. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> in_ready=0 for 33 cycles, out_valid on cycle 33, hi=0xFFFFFFFE, result=0x00000001. Also MULTU 0x1234*0 -> hi=0, result=0, zero=1.
5. Backpressure: issue AND a=0xF0F0 b=0xFF00, hold out_ready=0 for 5 cycles -> result=0xF000 stable, in_ready=0. Raise out_ready with in_valid OR -> drain and accept in the same cycle, OR result the next cycle.
6. Reset on cycle 10 of MULTU -> out_valid=0 and in_ready=1 next cycle. Subsequent NOR a=0 b=0 -> result=0xFFFFFFFF. op=0101 -> illegal_op=1, result=0.
